// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//
// Shared definitions for the registered 1-to-2 byte demultiplexer.
//
// Contents:
//   DEFAULT_WIDTH  default data width in bits
//   DEFAULT_DEPTH  default entries per channel buffer (power of two, >= 2)
//   COUNT_WIDTH    width of the per-channel traffic counters
//   CH0, CH1       channel index constants used to address per-channel vectors
//   clog2()        pointer-width helper usable in constant expressions
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;
  localparam int COUNT_WIDTH   = 8;

  // Channel indices; SEL = 0 routes to CH0 and SEL = 1 routes to CH1.
  localparam int CH0 = 0;
  localparam int CH1 = 1;

  // Ceiling log2, used to size buffer pointers. A depth of 2 gives a 1-bit
  // pointer; the occupancy counters use one extra bit so "full" is encodable.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
//
// One channel buffer of the demultiplexer: a small synchronous FIFO with
// registered pointers and occupancy, so empty/full are clean flop outputs.
//
// Parameters:
//   WIDTH      data width in bits
//   DEPTH      number of entries; must be a power of two, >= 2
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (pointers and occupancy only)
//   push       write push_data at the tail (ignored when full)
//   push_data  byte to store
//   pop        discard the head entry (ignored when empty)
//   head_data  current head entry; meaningful only when empty is 0
//   empty      occupancy == 0
//   full       occupancy == DEPTH
// -----------------------------------------------------------------------------
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = clog2(DEPTH);

  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   occ;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full buffer is dropped even if a pop happens on the same
  // edge; the freed slot only becomes visible to the writer one cycle later.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Status comes straight from the registered occupancy, so both flags are
  // glitch-free and carry no combinational path from push or pop.
  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);

  // The head is read asynchronously so it is valid in the same cycle the
  // occupancy becomes non-zero, giving one cycle of push-to-output latency.
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so both
  // pointers wrap naturally. A simultaneous push and pop leaves occupancy
  // unchanged while both pointers advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is deliberately not reset: clearing the pointers and occupancy
  // is enough to discard everything, and stale contents are never exposed
  // because the head is only meaningful while the buffer is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/demux_1to2_8b.sv
// -----------------------------------------------------------------------------
// demux_1to2_8b
//
// Registered 1-to-2 byte demultiplexer. Each byte on the input port is
// steered by SEL into one of two channel buffers, each of which drains
// independently through its own valid/ready port. Per-channel counters
// record how many bytes were accepted into each channel (modulo 256).
//
// Parameters:
//   WIDTH                   data width in bits
//   DEPTH                   entries per channel buffer (power of two, >= 2)
//
// Ports:
//   CLK                     rising-edge clock
//   RST_N                   asynchronous active-low reset
//   IN_DATA / IN_VALID      input byte and its qualifier
//   SEL                     0 routes to channel 0, 1 routes to channel 1
//   IN_READY                addressed channel can take a byte this cycle
//   OUTx_DATA / OUTx_VALID  head entry of channel x and non-empty flag
//   OUTx_READY              downstream consumes the head of channel x
//   COUNTx                  bytes accepted into channel x, modulo 256
// -----------------------------------------------------------------------------
module demux_1to2_8b
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [WIDTH-1:0]       IN_DATA,
  input  logic                   IN_VALID,
  input  logic                   SEL,
  output logic                   IN_READY,
  output logic [WIDTH-1:0]       OUT0_DATA,
  output logic [WIDTH-1:0]       OUT1_DATA,
  output logic                   OUT0_VALID,
  output logic                   OUT1_VALID,
  input  logic                   OUT0_READY,
  input  logic                   OUT1_READY,
  output logic [COUNT_WIDTH-1:0] COUNT0,
  output logic [COUNT_WIDTH-1:0] COUNT1
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic [1:0] full;
  logic [1:0] empty;
  logic       push0;
  logic       push1;

  // IN_READY looks only at the full flag of the addressed channel, so a
  // stalled channel never blocks traffic to the other one and a SEL change
  // is reflected in the same cycle. The full flags are registered, which
  // keeps OUTx_READY out of this path. Reset forces it low explicitly,
  // because the cleared occupancy alone would otherwise read as ready.
  assign IN_READY = RST_N & ~full[SEL];

  assign push0 = IN_VALID & IN_READY & ~SEL;
  assign push1 = IN_VALID & IN_READY &  SEL;

  assign OUT0_VALID = ~empty[CH0];
  assign OUT1_VALID = ~empty[CH1];

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chan0 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push0),
    .push_data (IN_DATA),
    .pop       (OUT0_READY),
    .head_data (OUT0_DATA),
    .empty     (empty[CH0]),
    .full      (full[CH0])
  );

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chan1 (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push1),
    .push_data (IN_DATA),
    .pop       (OUT1_READY),
    .head_data (OUT1_DATA),
    .empty     (empty[CH1]),
    .full      (full[CH1])
  );

  // Traffic counters count accepted input transfers only; pops do not
  // touch them, and they wrap silently from 255 back to 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      COUNT0 <= '0;
      COUNT1 <= '0;
    end else begin
      if (push0) begin
        COUNT0 <= COUNT0 + COUNT_ONE;
      end
      if (push1) begin
        COUNT1 <= COUNT1 + COUNT_ONE;
      end
    end
  end

endmodule
